// File: rtl/arb_types.sv
// Shared types for the memory arbiter: FSM state encoding and grant identity.
package arb_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_SERVE = 2'd1,
    D_SERVE = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } grant_t;

endpackage

// File: rtl/arb_select.sv
// Tie-break between icache and dcache requests. Define ARB_DCACHE_PRIORITY_EN
// to make the dcache win every tie; otherwise ties alternate against last_grant.
module arb_select
  import arb_types::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  grant_t last_grant,
  output grant_t grant
);

`ifdef ARB_DCACHE_PRIORITY_EN
  localparam bit DCACHE_PRIO = 1'b1;
`else
  localparam bit DCACHE_PRIO = 1'b0;
`endif

  always_comb begin
    grant = ICACHE;
    if (i_req && d_req) begin
      grant = (DCACHE_PRIO || last_grant == ICACHE) ? DCACHE : ICACHE;
    end else if (d_req) begin
      grant = DCACHE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache line transactions onto one physical memory port.
// Tie policy is selected by ARB_DCACHE_PRIORITY_EN (see arb_select).
module mem_arbiter
  import arb_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output arb_state_t        dbg_state
);

  // Handshake: a cache holds its request level until it sees its one-cycle
  // *_resp; memory holds pmem_read/pmem_write until pmem_resp is sampled high.

  arb_state_t state;
  grant_t     last_grant;
  grant_t     sel;
  logic       i_req;
  logic       d_req;

  assign i_req     = i_pmem_read;
  assign d_req     = d_pmem_read | d_pmem_write;
  assign dbg_state = state;

  arb_select u_select (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= ICACHE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      i_pmem_rdata <= '0;
      d_pmem_rdata <= '0;
      i_pmem_resp  <= 1'b0;
      d_pmem_resp  <= 1'b0;
    end else begin
      i_pmem_resp <= 1'b0;
      d_pmem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            last_grant <= sel;
            if (sel == DCACHE) begin
              // A write wins over a simultaneous (illegal) read request.
              state        <= D_SERVE;
              pmem_address <= d_pmem_address;
              pmem_wdata   <= d_pmem_wdata;
              pmem_write   <= d_pmem_write;
              pmem_read    <= ~d_pmem_write;
            end else begin
              state        <= I_SERVE;
              pmem_address <= i_pmem_address;
              pmem_write   <= 1'b0;
              pmem_read    <= 1'b1;
            end
          end
        end
        I_SERVE, D_SERVE: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            state      <= RESP;
            if (state == I_SERVE) begin
              i_pmem_rdata <= pmem_rdata;
              i_pmem_resp  <= 1'b1;
            end else begin
              d_pmem_rdata <= pmem_rdata;
              d_pmem_resp  <= 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  a_no_dcache_rd_wr: assert property (@(posedge clk) disable iff (rst)
    !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, tie/reset sequences
// and randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  import arb_types::*;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  typedef logic [LINE_W-1:0] line_t;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  arb_state_t        dbg_state;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int    n_checks = 0;
  int    n_fail   = 0;
  line_t exp_q[$];

  task automatic chk(input string name, input line_t act, input line_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents are a fixed function of the line address.
  function automatic line_t mem_line(input logic [ADDR_W-1:0] a);
    line_t l;
    for (int k = 0; k < LINE_W / 32; k++) l[k*32 +: 32] = a * 32'h9E37_79B1 + 32'(k);
    return l;
  endfunction

  // Reference arbitration rule: lone requester wins; a tie goes to the dcache
  // under priority mode, otherwise to whichever cache was not granted last.
  function automatic grant_t predict(input bit ir, input bit dr, input grant_t last);
    if (ir && dr) begin
`ifdef ARB_DCACHE_PRIORITY_EN
      return DCACHE;
`else
      return (last == DCACHE) ? ICACHE : DCACHE;
`endif
    end
    return dr ? DCACHE : ICACHE;
  endfunction

  // ---------------- driver / memory responder ----------------
  task automatic serve_one(input grant_t who, input bit wr, input logic [ADDR_W-1:0] addr,
                           input line_t wd, input int lat, input bit perturb, input bit drop,
                           output int waits);
    line_t line;
    bit    seen;
    line  = mem_line(addr);
    seen  = 1'b0;
    waits = 0;
    while (!seen && waits < 20) begin
      @(posedge clk); #1;
      waits++;
      seen = pmem_read | pmem_write;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: no pmem request within 20 cycles, required one for addr %h", addr);
      return;
    end
    exp_q.push_back(line);
    for (int k = 1; k <= lat; k++) begin
      chk("pmem_read", line_t'(pmem_read), line_t'(!wr));
      chk("pmem_write", line_t'(pmem_write), line_t'(wr));
      chk("pmem_address", line_t'(pmem_address), line_t'(addr));
      if (wr) chk("pmem_wdata", pmem_wdata, wd);
      chk("resp_during_service", line_t'({i_pmem_resp, d_pmem_resp}), line_t'(0));
      if (k == 1 && perturb) begin
        d_pmem_address = 32'h40;
        d_pmem_wdata   = ~d_pmem_wdata;
      end
      if (k == 1 && drop) begin
        i_pmem_read  = 1'b0;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
      end
      if (k == lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = line;
      end
      @(posedge clk); #1;
    end
    pmem_resp  = 1'b0;
    pmem_rdata = ~line;
    chk("pmem_req_after_resp", line_t'({pmem_read, pmem_write}), line_t'(0));
    chk("i_resp", line_t'(i_pmem_resp), line_t'(who == ICACHE));
    chk("d_resp", line_t'(d_pmem_resp), line_t'(who == DCACHE));
    chk("rdata", (who == ICACHE) ? i_pmem_rdata : d_pmem_rdata, exp_q.pop_front());
    @(posedge clk); #1;
    chk("resp_width", line_t'({i_pmem_resp, d_pmem_resp}), line_t'(0));
    chk("state_idle_after_resp", line_t'(dbg_state), line_t'(IDLE));
    chk("rdata_hold", (who == ICACHE) ? i_pmem_rdata : d_pmem_rdata, line);
  endtask

  task automatic clear_reqs();
    i_pmem_read  = 1'b0;
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit                ireq;
    bit                drd;
    bit                dwr;
    logic [ADDR_W-1:0] iaddr;
    logic [ADDR_W-1:0] daddr;
    line_t             wdata;
    int                lat;
    bit                perturb;
    bit                drop;
    grant_t            exp_who;
    bit                exp_wr;
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;

  function automatic vec_t mk(input bit ireq, input bit drd, input bit dwr,
                              input logic [ADDR_W-1:0] iaddr, input logic [ADDR_W-1:0] daddr,
                              input line_t wd, input int lat, input bit perturb, input bit drop,
                              input grant_t who, input bit wr, input logic [ADDR_W-1:0] ea);
    vec_t v;
    v.ireq = ireq; v.drd = drd; v.dwr = dwr; v.iaddr = iaddr; v.daddr = daddr;
    v.wdata = wd; v.lat = lat; v.perturb = perturb; v.drop = drop;
    v.exp_who = who; v.exp_wr = wr; v.exp_addr = ea;
    return v;
  endfunction

  vec_t   vecs[7];
  grant_t lg_model;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     waits;
    grant_t w;
    grant_t exp_w;
    bit     i_pend, d_pend, d_wr;
    logic [ADDR_W-1:0] ia, da;
    line_t  wd;

    vecs[0] = mk(1, 0, 0, 32'h0000_0060, 32'h0, line_t'(0), 5, 0, 0, ICACHE, 0, 32'h0000_0060);
    vecs[1] = mk(0, 0, 1, 32'h0, 32'h8000_0020, {32{8'hA5}}, 3, 0, 0, DCACHE, 1, 32'h8000_0020);
    vecs[2] = mk(0, 1, 0, 32'h0, 32'h0000_0020, line_t'(0), 4, 1, 0, DCACHE, 0, 32'h0000_0020);
    vecs[3] = mk(1, 0, 0, 32'h0000_1000, 32'h0, line_t'(0), 1, 0, 0, ICACHE, 0, 32'h0000_1000);
    vecs[4] = mk(0, 0, 1, 32'h0, 32'hFFFF_FFE0, {8{32'h0123_4567}}, 2, 1, 0, DCACHE, 1, 32'hFFFF_FFE0);
    vecs[5] = mk(0, 1, 0, 32'h0, 32'h0000_4000, line_t'(0), 3, 0, 1, DCACHE, 0, 32'h0000_4000);
    vecs[6] = mk(1, 0, 0, 32'h0000_0080, 32'h0, line_t'(0), 4, 0, 1, ICACHE, 0, 32'h0000_0080);

    // Reset state
    rst = 1'b1;
    clear_reqs();
    i_pmem_address = '0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", line_t'(dbg_state), line_t'(IDLE));
    chk("rst_pmem_req", line_t'({pmem_read, pmem_write}), line_t'(0));
    chk("rst_pmem_address", line_t'(pmem_address), line_t'(0));
    chk("rst_pmem_wdata", pmem_wdata, line_t'(0));
    chk("rst_resp", line_t'({i_pmem_resp, d_pmem_resp}), line_t'(0));
    chk("rst_i_rdata", i_pmem_rdata, line_t'(0));
    chk("rst_d_rdata", d_pmem_rdata, line_t'(0));
    rst = 1'b0;
    lg_model = ICACHE;

    // Ties straight after reset, both caches requesting continuously for 10 grants
    i_pmem_address = 32'h100;
    d_pmem_address = 32'h200;
    i_pmem_read = 1'b1;
    d_pmem_read = 1'b1;
    for (int g = 0; g < 10; g++) begin
`ifdef ARB_DCACHE_PRIORITY_EN
      exp_w = DCACHE;
`else
      exp_w = (g % 2 == 0) ? DCACHE : ICACHE;
`endif
      w = predict(1'b1, 1'b1, lg_model);
      chk("tie_rule", line_t'(w), line_t'(exp_w));
      serve_one(exp_w, 1'b0, (exp_w == ICACHE) ? 32'h100 : 32'h200, line_t'(0), 2, 0, 0, waits);
      if (g == 0) chk("tie_first_latency", line_t'(waits), line_t'(1));
      lg_model = exp_w;
    end
    clear_reqs();
    @(posedge clk); #1;

    // Directed single-requester vectors
    for (int i = 0; i < 7; i++) begin
      i_pmem_address = vecs[i].iaddr;
      d_pmem_address = vecs[i].daddr;
      d_pmem_wdata   = vecs[i].wdata;
      i_pmem_read    = vecs[i].ireq;
      d_pmem_read    = vecs[i].drd;
      d_pmem_write   = vecs[i].dwr;
      serve_one(vecs[i].exp_who, vecs[i].exp_wr, vecs[i].exp_addr, vecs[i].wdata,
                vecs[i].lat, vecs[i].perturb, vecs[i].drop, waits);
      chk("req_latency", line_t'(waits), line_t'(1));
      clear_reqs();
      lg_model = vecs[i].exp_who;
    end

    // Reset two cycles into a dcache write, with a memory response pending
    d_pmem_address = 32'h300;
    d_pmem_wdata   = {8{32'hDEAD_BEEF}};
    d_pmem_write   = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_write_c1", line_t'(pmem_write), line_t'(1));
    @(posedge clk); #1;
    chk("rstmid_write_c2", line_t'(pmem_write), line_t'(1));
    rst = 1'b1;
    pmem_resp = 1'b1;
    pmem_rdata = mem_line(32'h300);
    @(posedge clk); #1;
    chk("rstmid_write_low", line_t'(pmem_write), line_t'(0));
    chk("rstmid_no_resp", line_t'(d_pmem_resp), line_t'(0));
    chk("rstmid_state", line_t'(dbg_state), line_t'(IDLE));
    rst = 1'b0;
    pmem_resp = 1'b0;
    clear_reqs();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rstmid_quiet", line_t'({d_pmem_resp, pmem_write, pmem_read}), line_t'(0));
      chk("rstmid_d_rdata", d_pmem_rdata, line_t'(0));
    end
    lg_model = ICACHE;

    // Randomized traffic: each cache keeps a pending request until served
    i_pend = 1'b0; d_pend = 1'b0; d_wr = 1'b0;
    ia = '0; da = '0; wd = '0;
    for (int t = 0; t < 40; t++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1'b1;
        ia = $urandom & ~32'h1F;
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1'b1;
        da = $urandom & ~32'h1F;
        d_wr = 1'($urandom_range(0, 1));
        for (int k = 0; k < LINE_W / 32; k++) wd[k*32 +: 32] = $urandom;
      end
      if (!i_pend && !d_pend) begin
        i_pend = 1'b1;
        ia = $urandom & ~32'h1F;
      end
      i_pmem_address = ia;
      d_pmem_address = da;
      d_pmem_wdata   = wd;
      i_pmem_read    = i_pend;
      d_pmem_read    = d_pend && !d_wr;
      d_pmem_write   = d_pend && d_wr;
      w = predict(i_pend, d_pend, lg_model);
      serve_one(w, (w == DCACHE) ? d_wr : 1'b0, (w == DCACHE) ? da : ia, wd,
                $urandom_range(1, 6), 0, 0, waits);
      lg_model = w;
      if (w == DCACHE) begin
        d_pend = 1'b0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
      end else begin
        i_pend = 1'b0;
        i_pmem_read = 1'b0;
      end
    end
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    chk("final_idle", line_t'(dbg_state), line_t'(IDLE));
    chk("scoreboard_empty", line_t'(exp_q.size()), line_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 32, physical address width.
REQ-003 The block SHALL have these ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_pmem_read  in  1  icache line-fill request
- i_pmem_address  in  ADDR_W  icache line address
- i_pmem_rdata  out  LINE_W  fill data to icache
- i_pmem_resp  out  1  icache request complete
- d_pmem_read  in  1  dcache line-fill request
- d_pmem_write  in  1  dcache writeback request
- d_pmem_address  in  ADDR_W  dcache line address
- d_pmem_wdata  in  LINE_W  writeback data
- d_pmem_rdata  out  LINE_W  fill data to dcache
- d_pmem_resp  out  1  dcache request complete
- pmem_read  out  1  memory read request
- pmem_write  out  1  memory write request
- pmem_address  out  ADDR_W  memory line address
- pmem_wdata  out  LINE_W  memory write data
- pmem_rdata  in  LINE_W  memory read data
- pmem_resp  in  1  memory transaction complete

Function
REQ-004 The FSM SHALL have states IDLE, I_SERVE, D_SERVE and RESP.
REQ-005 IDLE with only icache requesting SHALL go to I_SERVE. IDLE with only dcache requesting SHALL go to D_SERVE. No request SHALL hold IDLE.
REQ-006 When both caches request in the same IDLE cycle, the winner SHALL be chosen per REQ-016/REQ-017.
REQ-007 On grant, the address, wdata and read/write type SHALL be latched. Memory outputs SHALL be driven from the latch and SHALL stay stable until pmem_resp, even if the cache changes its inputs.
REQ-008 pmem_read or pmem_write SHALL assert in the first cycle of I_SERVE/D_SERVE and SHALL stay high until pmem_resp is sampled. I_SERVE SHALL drive pmem_read only.
REQ-009 On pmem_resp, pmem_rdata SHALL be registered into the granted cache's rdata register, and the FSM SHALL go to RESP.
REQ-010 In RESP, the granted cache's *_resp SHALL be high for exactly one cycle, with its rdata valid that cycle. The FSM SHALL then return to IDLE.
REQ-011 Minimum latency SHALL be 3 cycles: cache request to pmem request is 1 cycle, and pmem_resp to cache resp is 1 cycle. Back-to-back grants SHALL be separated by at least one IDLE cycle so a dropped request is never re-granted.
REQ-012 The rdata output registers SHALL hold their last value outside RESP.
REQ-013 d_pmem_read and d_pmem_write both high SHALL be illegal. A simulation-only assertion SHALL fire on it, and the write SHALL be served.
REQ-014 A requester dropping its request mid-service SHALL NOT abort the memory transaction.

Reset
REQ-015 rst SHALL force IDLE, all *_resp and pmem_read/pmem_write to 0, the address/wdata/rdata registers to 0, and last_grant to ICACHE. Reset mid-transaction SHALL deassert pmem requests on the next edge and discard any pending pmem_resp.

Configuration
REQ-016 With macro ARB_DCACHE_PRIORITY_EN defined, a simultaneous request SHALL always grant the dcache.
REQ-017 Without ARB_DCACHE_PRIORITY_EN, a simultaneous request SHALL grant the requester not in last_grant. last_grant SHALL update on every grant. With last_grant at its reset value ICACHE, the first tie SHALL go to the dcache.

Structure
REQ-018 Package arb_types SHALL hold the arb_state_t enum (IDLE, I_SERVE, D_SERVE, RESP) and the grant_t enum (ICACHE, DCACHE).
REQ-019 The tie-break SHALL be a sub-module arb_select: combinational inputs i_req, d_req and last_grant, output grant_t.

Verification
REQ-020 The bench SHALL cover these scenarios:
- icache read of 0x0000_0060 alone, memory resp after 5 cycles -> pmem_read with address 0x60 for 5 cycles; i_pmem_resp one cycle later with rdata equal to the memory line.
- dcache write of 0x8000_0020 with wdata pattern A5..A5 -> pmem_write, address and wdata stable throughout; d_pmem_resp pulse width 1.
- Simultaneous icache and dcache read straight after reset, without the macro -> dcache served first, then icache; with the macro and a repeated tie -> dcache wins both times.
- Dcache changes its address to 0x40 while 0x20 is in service -> pmem_address stays 0x20 until resp.
- rst asserted 2 cycles into D_SERVE -> pmem_write low on the next cycle, no d_pmem_resp, FSM in IDLE.
- Continuous requests from both caches for 10 grants without the macro -> grants strictly alternate.
